memory_dump_io: RTL and testbench
=================================

// Module: memory_dump_io
// PURPOSE
// - Host-bound counterpart of the boot loader: reads a BRAM region and streams it out over the byte IO
//   (UART) write path in the same framing the loader accepts.
// - Framing: 2-byte big-endian length, then payload bytes, word MSB first (byte k = word[31-8*(k%4) -: 8]).
// - Sits beside the loader on the BRAM port mux and the UART TX side; used for memory readback/debug.
// PARAMETERS
// - RD_LAT    1      BRAM read latency in cycles (1..3); BRAM_RDDATA sampled RD_LAT cycles after BRAM_EN.
// - MAX_BYTES 65535  Largest accepted length; larger length_in is rejected.
// PORTS
// - CLK          in   1   clock; single clock domain
// - RSTN         in   1   asynchronous active-low reset
// - start        in   1   1-cycle pulse; latches base_addr/length_in when idle
// - base_addr    in   32  byte address of region; bits [1:0] ignored (word aligned)
// - length_in    in   16  payload byte count
// - BRAM_ADDR    out  32  word-aligned byte address
// - BRAM_EN      out  1   read strobe, 1 cycle per word
// - BRAM_WE      out  4   held 4'b0000 (read only)
// - BRAM_RDDATA  in   32  read data
// - io_ready     in   1   TX can accept a byte
// - io_write_req out  1   1-cycle request; io_wdata valid with it
// - io_done      in   1   TX finished current byte
// - io_wdata     out  8   byte to send; stable from req until io_done
// - busy         out  1   high from accepted start until done pulse
// - done         out  1   1-cycle pulse at end of frame (or on reject)
// - err          out  8   0 ok; 8'd1 length>MAX_BYTES; 8'd2 io_done with no request outstanding
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; all outputs 0; counters/addr 0. Reset mid-frame aborts it;
//   no partial-byte completion, io_write_req low immediately.
// - States: IDLE -> HDR_WAIT -> HDR_SEND (x2) -> MEM_REQ -> MEM_WAIT -> BYTE_WAIT -> BYTE_SEND -> ...
//   [-> CSUM_WAIT -> CSUM_SEND] -> FIN -> IDLE.
// - IDLE: start & length_in<=MAX_BYTES: latch, busy=1, err=0, go HDR_WAIT. start & too long: err=1,
//   done pulse next cycle, no IO/BRAM traffic, stay IDLE. start while busy ignored.
// - *_WAIT: when io_ready, drive io_wdata, pulse io_write_req one cycle, go *_SEND.
// - *_SEND: wait io_done; then advance. Header bytes: length[15:8] then length[7:0].
// - Length 0: header 00 00 only, then FIN.
// - MEM_REQ: BRAM_ADDR=base+4*word_idx, BRAM_EN=1 one cycle; MEM_WAIT counts RD_LAT, captures word.
//   BRAM read only when byte_idx[1:0]==0; next 3 bytes from captured word.
// - byte_idx 16-bit, compared to latched length; last word partial if length%4!=0 (excess bytes not sent).
// - BRAM_ADDR arithmetic 32-bit, wraps modulo 2^32 without error.
// - FIN: done=1 one cycle, busy=0, err unchanged until next accepted start.
// - io_done in any non-SEND state: err=2, ignored, frame continues. io_done and io_ready same cycle
//   in SEND: io_done completes byte; next request no earlier than following cycle.
// - Throughput: >=1 idle cycle between bytes; per-word overhead 1+RD_LAT cycles.
// CONFIGURATION
// - DUMP_CHECKSUM_EN defined: after payload send 1 trailer byte = 8-bit sum mod 256 of payload bytes
//   (header excluded); length 0 sends trailer 00.
// - Not defined: frame ends after last payload byte; CSUM states absent.
// TESTING
// - base=0, length=8, BRAM[0]=32'h11223344, [4]=32'h55667788, TX always ready -> bytes 00 08 11 22 33 44 55 66 77 88, done pulse.
// - length=5, BRAM[0x100]=DEADBEEF,[0x104]=CAFEF00D -> 00 05 DE AD BE EF CA; exactly 2 BRAM_EN pulses.
// - length=0 -> 00 00 then done; zero BRAM_EN pulses (with _EN: 00 00 00).
// - length_in=16'hFFFF with MAX_BYTES=1024 -> err=8'd1, done pulse, no io_write_req.
// - io_ready low 20 cycles mid-frame, io_done delayed 7 cycles -> io_wdata stable, single req per byte.
// - RSTN low during 3rd payload byte -> all outputs 0 at once; new start after release sends full frame.

Source files
------------

// File: rtl/memory_dump_io.sv
// memory_dump_io: reads a BRAM region and streams it over the byte TX path as [len_hi, len_lo, payload...].
// Build option DUMP_CHECKSUM_EN appends a one-byte additive checksum of the payload after the last byte.
module memory_dump_io #(
   parameter int RD_LAT    = 1,
   parameter int MAX_BYTES = 65535
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] length_in,
   output logic [31:0] BRAM_ADDR,
   output logic        BRAM_EN,
   output logic [3:0]  BRAM_WE,
   input  logic [31:0] BRAM_RDDATA,
   input  logic        io_ready,
   output logic        io_write_req,
   input  logic        io_done,
   output logic [7:0]  io_wdata,
   output logic        busy,
   output logic        done,
   output logic [7:0]  err
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR_WAIT,
      ST_HDR_SEND,
      ST_MEM_REQ,
      ST_MEM_WAIT,
      ST_BYTE_WAIT,
      ST_BYTE_SEND,
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_WAIT,
      ST_CSUM_SEND,
`endif
      ST_FIN
   } state_t;

`ifdef DUMP_CHECKSUM_EN
   localparam state_t ST_TAIL = ST_CSUM_WAIT;
`else
   localparam state_t ST_TAIL = ST_FIN;
`endif

   localparam logic [1:0] LAT = 2'(RD_LAT);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] byte_idx_q, byte_idx_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic        hdr_lo_q, hdr_lo_d;
   logic        req_q, req_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  err_q, err_d;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic [15:0] byte_nxt;
   logic        too_long;
   logic        in_send;
   logic [7:0]  payload_byte;

   assign byte_nxt = byte_idx_q + 16'd1;
   assign too_long = {16'd0, length_in} > 32'(MAX_BYTES);

`ifdef DUMP_CHECKSUM_EN
   assign in_send = (state_q == ST_HDR_SEND) || (state_q == ST_BYTE_SEND) || (state_q == ST_CSUM_SEND);
`else
   assign in_send = (state_q == ST_HDR_SEND) || (state_q == ST_BYTE_SEND);
`endif

   // Payload goes out MSB first within each captured word.
   always_comb begin
      case (byte_idx_q[1:0])
         2'd0:    payload_byte = word_q[31:24];
         2'd1:    payload_byte = word_q[23:16];
         2'd2:    payload_byte = word_q[15:8];
         default: payload_byte = word_q[7:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      addr_d     = addr_q;
      word_d     = word_q;
      lat_cnt_d  = lat_cnt_q;
      hdr_lo_d   = hdr_lo_q;
      req_d      = 1'b0;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef DUMP_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (too_long) begin
                  err_d  = 8'd1;
                  done_d = 1'b1;
               end else begin
                  len_d      = length_in;
                  addr_d     = base_addr & 32'hFFFF_FFFC;
                  byte_idx_d = 16'd0;
                  hdr_lo_d   = 1'b0;
                  busy_d     = 1'b1;
                  err_d      = 8'd0;
`ifdef DUMP_CHECKSUM_EN
                  csum_d     = 8'd0;
`endif
                  state_d    = ST_HDR_WAIT;
               end
            end
         end
         ST_HDR_WAIT: begin
            if (io_ready) begin
               req_d   = 1'b1;
               wdata_d = hdr_lo_q ? len_q[7:0] : len_q[15:8];
               state_d = ST_HDR_SEND;
            end
         end
         ST_HDR_SEND: begin
            if (io_done) begin
               if (!hdr_lo_q) begin
                  hdr_lo_d = 1'b1;
                  state_d  = ST_HDR_WAIT;
               end else if (len_q == 16'd0) begin
                  state_d = ST_TAIL;
               end else begin
                  state_d = ST_MEM_REQ;
               end
            end
         end
         ST_MEM_REQ: begin
            lat_cnt_d = 2'd1;
            state_d   = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (lat_cnt_q == LAT) begin
               word_d  = BRAM_RDDATA;
               addr_d  = addr_q + 32'd4;
               state_d = ST_BYTE_WAIT;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         ST_BYTE_WAIT: begin
            if (io_ready) begin
               req_d   = 1'b1;
               wdata_d = payload_byte;
               state_d = ST_BYTE_SEND;
            end
         end
         ST_BYTE_SEND: begin
            if (io_done) begin
               byte_idx_d = byte_nxt;
`ifdef DUMP_CHECKSUM_EN
               csum_d     = csum_q + wdata_q;
`endif
               if (byte_nxt == len_q)            state_d = ST_TAIL;
               else if (byte_nxt[1:0] == 2'd0)   state_d = ST_MEM_REQ;
               else                              state_d = ST_BYTE_WAIT;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CSUM_WAIT: begin
            if (io_ready) begin
               req_d   = 1'b1;
               wdata_d = csum_q;
               state_d = ST_CSUM_SEND;
            end
         end
         ST_CSUM_SEND: begin
            if (io_done) state_d = ST_FIN;
         end
`endif
         ST_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A completion with nothing outstanding is flagged but otherwise ignored.
      if (io_done && !in_send) err_d = 8'd2;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         byte_idx_q <= '0;
         addr_q     <= '0;
         word_q     <= '0;
         lat_cnt_q  <= '0;
         hdr_lo_q   <= 1'b0;
         req_q      <= 1'b0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         lat_cnt_q  <= lat_cnt_d;
         hdr_lo_q   <= hdr_lo_d;
         req_q      <= req_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Read strobe and address are decoded from state so the whole request costs one cycle.
   assign BRAM_EN      = (state_q == ST_MEM_REQ);
   assign BRAM_ADDR    = BRAM_EN ? addr_q : 32'd0;
   assign BRAM_WE      = 4'b0000;
   assign io_write_req = req_q;
   assign io_wdata     = wdata_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_memory_dump_io.sv
// Directed bench for memory_dump_io: BRAM model, TX model with configurable io_done delay, byte scoreboard.
module tb_memory_dump_io;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] length_in = '0;
   logic [31:0] BRAM_ADDR;
   logic        BRAM_EN;
   logic [3:0]  BRAM_WE;
   logic [31:0] BRAM_RDDATA;
   logic        io_ready = 1'b1;
   logic        io_write_req;
   logic        io_done = 1'b0;
   logic [7:0]  io_wdata;
   logic        busy;
   logic        done;
   logic [7:0]  err;

   always #5 CLK = ~CLK;

   memory_dump_io #(.RD_LAT(1), .MAX_BYTES(1024)) dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr), .length_in(length_in),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_RDDATA(BRAM_RDDATA),
      .io_ready(io_ready), .io_write_req(io_write_req), .io_done(io_done), .io_wdata(io_wdata),
      .busy(busy), .done(done), .err(err)
   );

   // One-cycle-latency synchronous BRAM, indexed by word address bits [9:2].
   logic [31:0] mem [0:255];
   logic [31:0] rd_q = '0;
   always @(posedge CLK) if (BRAM_EN) rd_q <= mem[BRAM_ADDR[9:2]];
   assign BRAM_RDDATA = rd_q;

   logic [7:0]  got[$];
   logic [31:0] en_addr[$];
   logic [7:0]  exp_q[$];
   int          en_cnt, done_cnt, bad_stable, bad_multi, bad_noready;
   int          tx_delay, dly, spur_cnt, spur_seen;
   int          n_chk, n_fail, frame_e0;
   logic        pend = 1'b0;
   logic [7:0]  pend_byte = '0;
   logic        rdy_pos = 1'b1;

   always @(posedge CLK) rdy_pos <= io_ready;

   // TX side model plus bus monitor, all sampled on the falling edge.
   always @(negedge CLK) begin
      io_done = 1'b0;
      if (!RSTN) begin
         pend = 1'b0;
      end else begin
         if (spur_cnt != spur_seen) begin
            io_done   = 1'b1;
            spur_seen = spur_cnt;
         end
         if (BRAM_EN) begin
            en_cnt++;
            en_addr.push_back(BRAM_ADDR);
         end
         if (done) done_cnt++;
         if (io_write_req) begin
            if (pend) bad_multi++;
            if (!rdy_pos) bad_noready++;
            got.push_back(io_wdata);
            pend      = 1'b1;
            pend_byte = io_wdata;
            dly       = tx_delay;
         end
         if (pend) begin
            if (io_wdata != pend_byte) bad_stable++;
            if (dly == 0) begin
               io_done = 1'b1;
               pend    = 1'b0;
            end else begin
               dly--;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_req"},   32'(io_write_req), 32'd0);
      chk({tag, "_en"},    32'(BRAM_EN),      32'd0);
      chk({tag, "_addr"},  BRAM_ADDR,         32'd0);
      chk({tag, "_we"},    32'(BRAM_WE),      32'd0);
      chk({tag, "_wdata"}, 32'(io_wdata),     32'd0);
      chk({tag, "_busy"},  32'(busy),         32'd0);
      chk({tag, "_done"},  32'(done),         32'd0);
      chk({tag, "_err"},   32'(err),          32'd0);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] base, input logic [15:0] len, input int exp_en);
      int g0, d0, k;
      g0 = got.size();
      d0 = done_cnt;
      frame_e0 = en_cnt;
      @(negedge CLK);
      base_addr = base;
      length_in = len;
      start     = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      k = 0;
      while (done_cnt == d0 && k < 3000) begin
         @(negedge CLK);
         k++;
      end
      chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
      repeat (4) @(negedge CLK);
      chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_nbytes"}, 32'(got.size() - g0), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_b%0d", tag, i),
             (g0 + i < got.size()) ? 32'(got[g0 + i]) : 32'hDEAD_0000, 32'(exp_q[i]));
      chk({tag, "_en_cnt"}, 32'(en_cnt - frame_e0), 32'(exp_en));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, d0, k, s0, m0, r0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0]   = 32'h1122_3344;
      mem[1]   = 32'h5566_7788;
      mem[64]  = 32'hDEAD_BEEF;
      mem[65]  = 32'hCAFE_F00D;
      mem[255] = 32'hAABB_CCDD;
      tx_delay = 0;

      repeat (3) @(negedge CLK);
      chk_idle_outs("rst");
      RSTN = 1'b1;
      @(negedge CLK);

      // Two full words from address 0.
      exp_q = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'h64);
`endif
      run_frame("A", 32'h0, 16'd8, 2);

      // Unaligned base is rounded down; partial last word.
      exp_q = '{8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'h02);
`endif
      run_frame("B", 32'h103, 16'd5, 2);
      chk("B_addr0", en_addr[frame_e0], 32'h100);
      chk("B_addr1", en_addr[frame_e0 + 1], 32'h104);

      // Empty payload.
      exp_q = '{8'h00, 8'h00};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'h00);
`endif
      run_frame("C", 32'h40, 16'd0, 0);

      // Address wraps past 2^32.
      exp_q = '{8'h00, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'hB8);
`endif
      run_frame("W", 32'hFFFF_FFFC, 16'd8, 2);
      chk("W_addr0", en_addr[frame_e0], 32'hFFFF_FFFC);
      chk("W_addr1", en_addr[frame_e0 + 1], 32'h0);

      // Oversized lengths are rejected without any traffic.
      for (int t = 0; t < 2; t++) begin
         g0 = got.size(); d0 = done_cnt; frame_e0 = en_cnt;
         @(negedge CLK);
         length_in = (t == 0) ? 16'hFFFF : 16'd1025;
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         chk($sformatf("D%0d_busy", t), 32'(busy), 32'd0);
         chk($sformatf("D%0d_err", t), 32'(err), 32'd1);
         repeat (4) @(negedge CLK);
         chk($sformatf("D%0d_done", t), 32'(done_cnt - d0), 32'd1);
         chk($sformatf("D%0d_req", t), 32'(got.size() - g0), 32'd0);
         chk($sformatf("D%0d_en", t), 32'(en_cnt - frame_e0), 32'd0);
      end

      // Stalled TX ready and slow completions.
      s0 = bad_stable; m0 = bad_multi; r0 = bad_noready;
      tx_delay = 7;
      exp_q = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'h64);
`endif
      fork
         run_frame("E", 32'h0, 16'd8, 2);
         begin
            repeat (30) @(negedge CLK);
            io_ready = 1'b0;
            repeat (20) @(negedge CLK);
            io_ready = 1'b1;
         end
      join
      chk("E_stable", 32'(bad_stable - s0), 32'd0);
      chk("E_multi", 32'(bad_multi - m0), 32'd0);
      chk("E_noready", 32'(bad_noready - r0), 32'd0);

      // Stray completion while idle.
      @(negedge CLK);
      spur_cnt++;
      repeat (3) @(negedge CLK);
      chk("G_err", 32'(err), 32'd2);
      chk("G_busy", 32'(busy), 32'd0);

      // Reset during the third payload byte.
      tx_delay = 3;
      g0 = got.size();
      @(negedge CLK);
      base_addr = 32'h0; length_in = 16'd8; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      k = 0;
      while (got.size() - g0 < 5 && k < 500) begin
         @(negedge CLK);
         k++;
      end
      chk("F_reach", 32'(got.size() - g0), 32'd5);
      #2 RSTN = 1'b0;
      #1 chk_idle_outs("F_rst");
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
      tx_delay = 0;
      exp_q = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(8'h64);
`endif
      run_frame("F2", 32'h0, 16'd8, 2);

      chk("all_stable", 32'(bad_stable), 32'd0);
      chk("all_multi", 32'(bad_multi), 32'd0);
      chk("all_noready", 32'(bad_noready), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
